ahb_bus_controller: RTL

// Arbitrates two AHB-lite style masters onto the shared system bus, decodes the granted

---
 rtl/ahb_bus_controller.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_bus_controller.sv
// ahb_bus_controller
// Two-master AHB-lite arbiter with address decode, registered data-phase
// read-mux select (SEL), per-grant burst limiting, unmapped-address error
// responses and a slave wait-state timeout that ends in an ERROR response.
module ahb_bus_controller #(
   parameter int ADDR_W    = 32,
   parameter int BURST_MAX = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              HBUSREQ_1,
   input  logic              HBUSREQ_2,
   input  logic [1:0]        HTRANS_1,
   input  logic [1:0]        HTRANS_2,
   input  logic [ADDR_W-1:0] HADDR_1,
   input  logic [ADDR_W-1:0] HADDR_2,
   input  logic              HREADY_1,
   input  logic              HREADY_2,
   input  logic              HREADY_3,
   output logic              HGRANT_1,
   output logic              HGRANT_2,
   output logic              HMASTER,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HSEL_1,
   output logic              HSEL_2,
   output logic              HSEL_3,
   output logic [1:0]        SEL,
   output logic              HREADY,
   output logic              HRESP
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   // Registered controller state
   state_t     state_reg;
   logic       grant1_reg;
   logic       grant2_reg;
   logic       hmaster_reg;
   logic       last_served_reg;   // 0 = M1, 1 = M2
   logic [1:0] sel_reg;
   logic [7:0] beat_cnt_reg;
   logic [7:0] wait_cnt_reg;

   // Combinational helpers
   logic       granted;
   logic [1:0] owner_trans;
   logic       trans_active;
   logic [1:0] region;
   logic       hready_bus;
   logic       owner_req;
   logic       other_req;
   logic [7:0] beat_cnt_next;
   logic       burst_done;
   logic       rearb;
   logic       idle_pick_m2;
   logic [2:0] hsel_vec;

   assign granted = grant1_reg | grant2_reg;

   // Address and transfer type of the current owner; 01 (BUSY) is folded into IDLE,
   // so only bit 1 distinguishes an active transfer.
   assign HADDR        = hmaster_reg ? HADDR_2 : HADDR_1;
   assign owner_trans  = hmaster_reg ? HTRANS_2 : HTRANS_1;
   assign trans_active = granted & owner_trans[1];
   assign HTRANS       = trans_active ? owner_trans : 2'b00;

   // Slave region from the top two address bits; region 0 is unmapped
   assign region = HADDR[ADDR_W-1 -: 2];

   // One address-phase select per mapped region
   for (genvar gi = 0; gi < 3; gi++) begin : g_hsel
      assign hsel_vec[gi] = trans_active && (region == 2'(gi + 1));
   end

   assign HSEL_1 = hsel_vec[0];
   assign HSEL_2 = hsel_vec[1];
   assign HSEL_3 = hsel_vec[2];

   // Bus ready: forced low in the first error cycle, otherwise from the data-phase slave
   always_comb begin
      hready_bus = 1'b1;
      if (state_reg == ST_ERR1) begin
         hready_bus = 1'b0;
      end else begin
         case (sel_reg)
            2'b01:   hready_bus = HREADY_1;
            2'b10:   hready_bus = HREADY_2;
            2'b11:   hready_bus = HREADY_3;
            default: hready_bus = 1'b1;
         endcase
      end
   end

   assign HREADY   = hready_bus;
   assign HRESP    = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
   assign HGRANT_1 = grant1_reg;
   assign HGRANT_2 = grant2_reg;
   assign HMASTER  = hmaster_reg;
   assign SEL      = sel_reg;

   // Arbitration decisions evaluated for the current cycle
   always_comb begin
      owner_req     = hmaster_reg ? HBUSREQ_2 : HBUSREQ_1;
      other_req     = hmaster_reg ? HBUSREQ_1 : HBUSREQ_2;
      beat_cnt_next = beat_cnt_reg + {7'd0, trans_active};
      // The limit is judged on the count including a beat accepted this edge, so the
      // grant moves on the very edge that accepts the last permitted beat.
      burst_done    = (beat_cnt_next >= 8'(BURST_MAX));
      rearb         = !owner_req
                      || (other_req && burst_done)
                      || (other_req && !trans_active);
      // From IDLE a tie goes to whichever master was not served last
      idle_pick_m2  = HBUSREQ_2 && (!HBUSREQ_1 || !last_served_reg);
   end

   // Controller FSM: grant hand-over, data-phase select, beat and wait counting, errors
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_reg       <= ST_IDLE;
         grant1_reg      <= 1'b0;
         grant2_reg      <= 1'b0;
         hmaster_reg     <= 1'b0;
         last_served_reg <= 1'b1;
         sel_reg         <= 2'b00;
         beat_cnt_reg    <= 8'd0;
         wait_cnt_reg    <= 8'd0;
      end else begin
         case (state_reg)
            ST_ERR1: begin
               state_reg <= ST_ERR2;
            end

            ST_ERR2: begin
               // Grant is untouched by an error; only the burst count restarts
               state_reg    <= granted ? ST_OWN : ST_IDLE;
               beat_cnt_reg <= 8'd0;
            end

            default: begin
               if (!hready_bus) begin
                  // Data phase stalled: count toward the timeout, grant frozen
                  if (wait_cnt_reg == 8'(TIMEOUT - 1)) begin
                     state_reg    <= ST_ERR1;
                     sel_reg      <= 2'b00;
                     wait_cnt_reg <= 8'd0;
                  end else begin
                     wait_cnt_reg <= wait_cnt_reg + 8'd1;
                  end
               end else begin
                  wait_cnt_reg <= 8'd0;
                  sel_reg      <= trans_active ? region : 2'b00;

                  if (trans_active && (region == 2'b00)) begin
                     // Unmapped address: answer with a two-cycle ERROR, keep the grant
                     state_reg    <= ST_ERR1;
                     beat_cnt_reg <= beat_cnt_next;
                  end else if (state_reg == ST_IDLE) begin
                     beat_cnt_reg <= 8'd0;
                     if (HBUSREQ_1 || HBUSREQ_2) begin
                        state_reg   <= ST_OWN;
                        grant1_reg  <= !idle_pick_m2;
                        grant2_reg  <= idle_pick_m2;
                        hmaster_reg <= idle_pick_m2;
                     end
                  end else if (rearb) begin
                     beat_cnt_reg    <= 8'd0;
                     last_served_reg <= hmaster_reg;
                     if (other_req) begin
                        grant1_reg  <= hmaster_reg;
                        grant2_reg  <= !hmaster_reg;
                        hmaster_reg <= !hmaster_reg;
                     end else begin
                        // Nobody left requesting; HMASTER keeps its last value
                        state_reg  <= ST_IDLE;
                        grant1_reg <= 1'b0;
                        grant2_reg <= 1'b0;
                     end
                  end else if (burst_done) begin
                     // Owner is the only requester: it keeps the bus, count restarts
                     beat_cnt_reg <= 8'd0;
                  end else begin
                     beat_cnt_reg <= beat_cnt_next;
                  end
               end
            end
         endcase
      end
   end

endmodule
